qft_shot_sampler: RTL
=====================

QFT_SHOT_SAMPLER -- requirements
Module: qft_shot_sampler

Interface
REQ-001 SHALL have parameter SHOT_W, default 16, giving the shot-count and histogram counter width.
REQ-002 SHALL have parameter SEED_DEFAULT, default 16'hACE1, giving the LFSR value used after reset or on a zero seed load.
REQ-003 SHALL take the magnitude width from the shared `TOTAL_BITS`/`FX_BITS` defines; no local redefinition.
REQ-004 SHALL have port: clk  in  1  sole clock; all state updates on its rising edge.
REQ-005 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port: start  in  1  request a sampling run; sampled only in IDLE.
REQ-007 SHALL have port: num_shots  in  SHOT_W  shots to draw; latched on accepted start.
REQ-008 SHALL have port: mag_sq_in  in  `TOTAL_BITS*4  four magnitude-squared values, |00> in the MSB field and |11> in the LSB field (magnitudes-stage output format); latched on accepted start.
REQ-009 SHALL have port: seed_load / seed  in  1 / 16  load seed into the LFSR; honoured only in IDLE.
REQ-010 SHALL have port: busy  out  1  high in LOAD, DRAW and DONE.
REQ-011 SHALL have port: sample_valid / sample_out  out  1 / 2  one drawn basis index per valid cycle.
REQ-012 SHALL have port: done  out  1  single-cycle end-of-run pulse.
REQ-013 SHALL have port: err_zero  out  1  the latched distribution summed to zero; held until the next accepted start.
REQ-014 SHALL have port: hist_out  out  4*SHOT_W  per-basis shot counts in the same field order as mag_sq_in, held after done.

Function
REQ-015 SHALL implement the FSM states IDLE, LOAD, DRAW and DONE with these transitions:
- IDLE to LOAD on start;
- LOAD to DRAW when num_shots > 0 and total > 0, otherwise LOAD to DONE;
- DRAW to DONE after the last shot;
- DONE to IDLE unconditionally.
REQ-016 SHALL, on accepted start, clear hist_out and err_zero and latch mag_sq_in and num_shots.
REQ-017 SHALL treat each latched magnitude as signed and clamp negative values to 0.
REQ-018 SHALL, in LOAD, form the cumulative sums c0..c3 at width `TOTAL_BITS+2 with no overflow; the total is c3.
REQ-019 SHALL set err_zero in LOAD when the total is 0.
REQ-020 SHALL, in each DRAW cycle:
- compute r = (lfsr * total) >> 16;
- select the lowest index i with r < ci;
- register i to sample_out with sample_valid=1 in the next cycle;
- increment hist[i];
- advance the LFSR once.
REQ-021 SHALL implement the LFSR as a 16-bit Fibonacci LFSR with taps x^16+x^14+x^13+x^11+1 that never holds 0; a seed of 0 SHALL load SEED_DEFAULT.
REQ-022 SHALL issue one shot per cycle and no stalls: with start accepted at edge k, sample_valid is high for exactly num_shots cycles starting at edge k+2 and done pulses at edge k+2+num_shots.
REQ-023 SHALL, for num_shots=0 or total=0, pulse done at edge k+2 with no sample_valid and a zero histogram.
REQ-024 SHALL ignore start while busy, including in the DONE cycle.
REQ-025 SHALL NOT saturate or wrap the histogram counters; the sum of all bins SHALL equal num_shots at done.
REQ-026 SHALL ignore mag_sq_in and num_shots changes after the accepted start.

Reset
REQ-027 SHALL, while rst_n=0 and at any point mid-run, force:
- state to IDLE;
- busy, sample_valid, done and err_zero to 0;
- sample_out to 0 and hist_out to 0;
- the LFSR to SEED_DEFAULT;
- the latched magnitudes and num_shots to 0.
REQ-028 SHALL accept start on the first rising edge after rst_n deasserts.

Structure
REQ-029 SHALL keep the LFSR tap mask, SEED_DEFAULT and the FSM state encodings with the shared fixed-point defines in fixed_complex_utils.v.
REQ-030 SHALL place the LFSR in one sub-module, lfsr16, with ports clk, rst_n, load, seed, en and q.
REQ-031 SHALL keep the cumulative-compare and scaling logic inline, with a single multiplier of 16 x (`TOTAL_BITS+2) bits.

Verification
REQ-032 SHALL check: mags {1.0,0,0,0}, num_shots=100 -> 100 samples all 0, hist {100,0,0,0}, done at start+102.
REQ-033 SHALL check: QFT |01> magnitudes {0.25,0.25,0.25,0.25}, num_shots=1000 -> every bin within 250±60 and bins sum to 1000.
REQ-034 SHALL check: mags all zero, num_shots=50 -> err_zero=1, no sample_valid, done at start+2, hist all 0.
REQ-035 SHALL check: seed=16'h1234 loaded twice, each followed by the same 20-shot run -> identical sample_out sequences; seed=0 -> sequence matches SEED_DEFAULT.
REQ-036 SHALL check: rst_n pulsed low during DRAW after 7 shots -> all outputs 0 immediately, IDLE; a following run is correct.
REQ-037 SHALL check: start reasserted during DRAW and during DONE -> ignored, no extra samples, single done pulse.

Source files
------------

// File: rtl/qft_shot_sampler_pkg.sv
// Package for the shot sampler: widths derived from the shared fixed-point
// defines, the FSM state type and the LFSR next-state helper.
`include "fixed_complex_utils.sv"

package qft_shot_sampler_pkg;

    localparam int TOTAL_BITS = `TOTAL_BITS;
    localparam int NUM_BASIS  = 4;
    // Four clamped non-negative magnitudes summed need two extra bits.
    localparam int CUM_W      = `TOTAL_BITS + 2;
    localparam int LFSR_W     = 16;
    localparam int PROD_W     = LFSR_W + CUM_W;

    localparam logic [15:0] LFSR_TAPS         = `LFSR16_TAPS;
    localparam logic [15:0] LFSR_SEED_DEFAULT = `LFSR16_SEED_DEFAULT;

    typedef enum logic [1:0] {
        ST_IDLE = `QSS_ST_IDLE,
        ST_LOAD = `QSS_ST_LOAD,
        ST_DRAW = `QSS_ST_DRAW,
        ST_DONE = `QSS_ST_DONE
    } state_t;

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [15:0] lfsr16_next(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/qft_shot_sampler_if.sv
// Bundle of the sampler's control, data and result signals.
//   master : the requester (drives start/num_shots/mag_sq_in/seed_load/seed)
//   slave  : the sampler (drives busy/sample_valid/sample_out/done/err_zero/hist_out)
// mag_sq_in and hist_out carry basis |00> in the MSB field and |11> in the LSB field.
interface qft_shot_sampler_if
    import qft_shot_sampler_pkg::*;
#(
    parameter int SHOT_W = 16
);
    logic                          start;
    logic [SHOT_W-1:0]             num_shots;
    logic [NUM_BASIS*TOTAL_BITS-1:0] mag_sq_in;
    logic                          seed_load;
    logic [15:0]                   seed;
    logic                          busy;
    logic                          sample_valid;
    logic [1:0]                    sample_out;
    logic                          done;
    logic                          err_zero;
    logic [NUM_BASIS*SHOT_W-1:0]   hist_out;

    modport master (
        output start, num_shots, mag_sq_in, seed_load, seed,
        input  busy, sample_valid, sample_out, done, err_zero, hist_out
    );

    modport slave (
        input  start, num_shots, mag_sq_in, seed_load, seed,
        output busy, sample_valid, sample_out, done, err_zero, hist_out
    );
endinterface

// File: rtl/fixed_complex_utils.sv
// Shared fixed-point and sampler constants.
// TOTAL_BITS/FX_BITS describe the signed magnitude format (Q2.14 by default).
// The LFSR tap mask, its reset/zero-seed value and the sampler FSM encodings
// live here too, so every stage that uses them agrees on a single definition.
`ifndef FIXED_COMPLEX_UTILS_SV
`define FIXED_COMPLEX_UTILS_SV

`define TOTAL_BITS          16
`define FX_BITS             14

// x^16 + x^14 + x^13 + x^11 + 1 -> state bits 15, 13, 12, 10
`define LFSR16_TAPS         16'hB400
`define LFSR16_SEED_DEFAULT 16'hACE1

`define QSS_ST_IDLE         2'd0
`define QSS_ST_LOAD         2'd1
`define QSS_ST_DRAW         2'd2
`define QSS_ST_DONE         2'd3

`endif

// File: rtl/qft_shot_sampler_lfsr16.sv
// lfsr16: 16-bit Fibonacci LFSR used as the sampler's random source.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low reset, loads SEED_DEFAULT
//   load  : load seed (a zero seed loads SEED_DEFAULT so the state is never 0)
//   seed  : seed value
//   en    : advance one step
//   q     : current state
module lfsr16
    import qft_shot_sampler_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
)(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] seed,
    input  logic        en,
    output logic [15:0] q
);

    logic [15:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= SEED_DEFAULT;
        end else if (load) begin
            r_q <= (seed == 16'd0) ? SEED_DEFAULT : seed;
        end else if (en) begin
            r_q <= lfsr16_next(r_q);
        end
    end

    assign q = r_q;

endmodule

// File: rtl/qft_shot_sampler.sv
// qft_shot_sampler: draws measurement shots from a 4-entry probability
// distribution (magnitude-squared values of a 2-qubit state) and builds a
// per-basis histogram.  One shot per cycle, no stalls.
// Ports:
//   clk   : clock, all state updates on its rising edge
//   rst_n : asynchronous active-low reset
//   bus   : qft_shot_sampler_if.slave
//           start/num_shots/mag_sq_in : run request, latched when accepted in IDLE
//           seed_load/seed            : reseed the LFSR (IDLE only)
//           busy                      : high in LOAD, DRAW and DONE
//           sample_valid/sample_out   : one drawn basis index per valid cycle
//           done                      : one-cycle end-of-run pulse
//           err_zero                  : latched distribution summed to zero
//           hist_out                  : per-basis counts, held after done
// The interface instance must be built with the same SHOT_W as this module.
module qft_shot_sampler
    import qft_shot_sampler_pkg::*;
#(
    parameter int          SHOT_W       = 16,
    parameter logic [15:0] SEED_DEFAULT = LFSR_SEED_DEFAULT
)(
    input  logic               clk,
    input  logic               rst_n,
    qft_shot_sampler_if.slave  bus
);

    state_t                r_state;
    logic [TOTAL_BITS-1:0] r_mag [NUM_BASIS];
    logic [SHOT_W-1:0]     r_num_shots;   // counts down the shots still to draw
    logic [SHOT_W-1:0]     r_hist [NUM_BASIS];
    logic                  r_busy;
    logic                  r_sample_valid;
    logic [1:0]            r_sample_out;
    logic                  r_done;
    logic                  r_err_zero;

    logic [TOTAL_BITS-1:0] w_mag_clamped [NUM_BASIS];
    logic [CUM_W-1:0]      w_cum0;
    logic [CUM_W-1:0]      w_cum1;
    logic [CUM_W-1:0]      w_cum2;
    logic [CUM_W-1:0]      w_cum3;
    logic [15:0]           w_lfsr_q;
    logic                  w_lfsr_load;
    logic                  w_lfsr_en;
    logic [PROD_W-1:0]     w_prod;
    logic [CUM_W-1:0]      w_r;
    logic [1:0]            w_idx;

    // Magnitudes are signed; a negative value carries no probability mass.
    // hist_out keeps the same MSB-first field order as mag_sq_in.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BASIS; gi++) begin : g_basis
            assign w_mag_clamped[gi] = r_mag[gi][TOTAL_BITS-1] ? '0 : r_mag[gi];
            assign bus.hist_out[(NUM_BASIS-1-gi)*SHOT_W +: SHOT_W] = r_hist[gi];
        end
    endgenerate

    assign w_cum0 = CUM_W'(w_mag_clamped[0]);
    assign w_cum1 = w_cum0 + CUM_W'(w_mag_clamped[1]);
    assign w_cum2 = w_cum1 + CUM_W'(w_mag_clamped[2]);
    assign w_cum3 = w_cum2 + CUM_W'(w_mag_clamped[3]);

    // Scale the 16-bit random value into [0, total): r = (lfsr * total) >> 16.
    // Since lfsr < 2^16, r < total = c3 always, so index 3 is the fallback.
    assign w_prod = PROD_W'(w_lfsr_q) * PROD_W'(w_cum3);
    assign w_r    = CUM_W'(w_prod >> LFSR_W);

    always_comb begin
        w_idx = 2'd3;
        if (w_r < w_cum0) begin
            w_idx = 2'd0;
        end else if (w_r < w_cum1) begin
            w_idx = 2'd1;
        end else if (w_r < w_cum2) begin
            w_idx = 2'd2;
        end
    end

    assign w_lfsr_load = bus.seed_load && (r_state == ST_IDLE);
    assign w_lfsr_en   = (r_state == ST_DRAW);

    lfsr16 #(
        .SEED_DEFAULT (SEED_DEFAULT)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_lfsr_load),
        .seed  (bus.seed),
        .en    (w_lfsr_en),
        .q     (w_lfsr_q)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_num_shots    <= '0;
            r_busy         <= 1'b0;
            r_sample_valid <= 1'b0;
            r_sample_out   <= 2'd0;
            r_done         <= 1'b0;
            r_err_zero     <= 1'b0;
            for (int i = 0; i < NUM_BASIS; i++) begin
                r_mag[i]  <= '0;
                r_hist[i] <= '0;
            end
        end else begin
            r_done         <= 1'b0;
            r_sample_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state     <= ST_LOAD;
                        r_busy      <= 1'b1;
                        r_err_zero  <= 1'b0;
                        r_num_shots <= bus.num_shots;
                        for (int i = 0; i < NUM_BASIS; i++) begin
                            r_mag[i]  <= bus.mag_sq_in[(NUM_BASIS-1-i)*TOTAL_BITS +: TOTAL_BITS];
                            r_hist[i] <= '0;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_cum3 == '0) begin
                        r_err_zero <= 1'b1;
                    end
                    if ((r_num_shots != '0) && (w_cum3 != '0)) begin
                        r_state <= ST_DRAW;
                    end else begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DRAW: begin
                    r_sample_valid <= 1'b1;
                    r_sample_out   <= w_idx;
                    r_hist[w_idx]  <= r_hist[w_idx] + SHOT_W'(1);
                    r_num_shots    <= r_num_shots - SHOT_W'(1);
                    if (r_num_shots == SHOT_W'(1)) begin
                        r_state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // done is registered here so it lands one cycle after the
                    // last sample, while start is still ignored in this cycle.
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy         = r_busy;
    assign bus.sample_valid = r_sample_valid;
    assign bus.sample_out   = r_sample_out;
    assign bus.done         = r_done;
    assign bus.err_zero     = r_err_zero;

endmodule
